// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register that carries a control payload and a datapath payload, with a valid/ready handshake, flush and a back-pressure counter.
// Define PIPE_STAGE_SKID_EN for a two-entry skid buffer with a registered ready_o; leave it undefined for a single entry with a combinational ready_o.
module pipe_stage_reg #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    entry_t           in_ent;
    entry_t           main_q;
    logic             valid_q;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] cnt_q;

    assign in_ent.ctrl = ctrl_i;
    assign in_ent.data = data_i;
    assign in_xfer     = valid_i & ready_o;
    assign out_xfer    = valid_q & ready_i;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t state_q, state_d;
    entry_t skid_q;
    logic   ready_q;
    logic   load_main, load_skid, pop_skid, clr_main;

    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
        load_skid = 1'b0;
        pop_skid  = 1'b0;
        clr_main  = 1'b0;
        if (flush_i) begin
            state_d  = ST_EMPTY;
            clr_main = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        load_main = 1'b1;
                        state_d   = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_d   = ST_FULL;
                    end else if (out_xfer) begin
                        clr_main = 1'b1;
                        state_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so only the drain side can move
                    if (out_xfer) begin
                        pop_skid = 1'b1;
                        state_d  = ST_ONE;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    clr_main = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d != ST_FULL);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)
                main_q <= in_ent;
            else if (pop_skid)
                main_q <= skid_q;
            else if (clr_main)
                main_q.ctrl <= '0;
            if (load_skid)
                skid_q <= in_ent;
        end
    end

    assign valid_q = (state_q != ST_EMPTY);
    assign ready_o = ready_q;
`else
    // A held entry can still be replaced in the same cycle it drains
    assign ready_o = !valid_q | ready_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            main_q  <= '0;
        end else if (flush_i) begin
            valid_q     <= 1'b0;
            main_q.ctrl <= '0;
        end else if (in_xfer) begin
            valid_q <= 1'b1;
            main_q  <= in_ent;
        end else if (out_xfer) begin
            valid_q     <= 1'b0;
            main_q.ctrl <= '0;
        end
    end
`endif

    // Flush outranks a back-pressured cycle, so it is not counted
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            cnt_q <= '0;
        else if (valid_q && !ready_i && !flush_i && (cnt_q != CNT_MAX))
            cnt_q <= cnt_q + 1'b1;
    end

    assign valid_o     = valid_q;
    assign ctrl_o      = main_q.ctrl;
    assign data_o      = main_q.data;
    assign stall_cnt_o = cnt_q;

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register, successor to the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the RISC-V pipeline. It carries one control payload and one datapath payload across a stage boundary with a valid/ready handshake, synchronous flush and bubble insertion. It also keeps a saturating back-pressure counter. Every inter-stage register in the core instantiates this block with its own widths.

## Interface
Parameters:
- `CTRL_W`, default 8: control payload width (RegWrite, MemtoReg, MemRead, MemWrite, ALUOp, ALUSrc, ...). Forced to zero on bubble or flush.
- `DATA_W`, default 128: datapath payload width (operands, immediate, funct, register addresses). Never cleared except by reset.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk_i`, in, 1: clock.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `flush_i`, in, 1: synchronous kill of every entry held in the stage.
- `valid_i`, in, 1: upstream entry valid.
- `ready_o`, out, 1: stage can accept an entry.
- `ctrl_i`, in, CTRL_W: control payload in.
- `data_i`, in, DATA_W: datapath payload in.
- `valid_o`, out, 1: output entry valid.
- `ready_i`, in, 1: downstream accepts the output entry.
- `ctrl_o`, out, CTRL_W: control payload out.
- `data_o`, out, DATA_W: datapath payload out.
- `stall_cnt_o`, out, CNT_W: count of back-pressured cycles.

## Operation
- Input transfer occurs when `valid_i & ready_o`. Output transfer occurs when `valid_o & ready_i`.
- Invariant: `valid_o == 0` implies `ctrl_o == 0`. `data_o` holds its last value when invalid.
- Base mode (single entry):
  - `ready_o = !valid_o | ready_i`, a combinational path.
  - On input transfer: load `ctrl_o`/`data_o`, set `valid_o` = 1.
  - On output transfer with no input transfer: `valid_o` = 0, `ctrl_o` = 0.
- Skid mode (see Configuration): two entries, main (drives the outputs) and skid. States are EMPTY, ONE and FULL.
  - EMPTY, input transfer: load main, go to ONE.
  - ONE, input and output transfer: load main with the new entry, stay in ONE.
  - ONE, input transfer only: write skid, go to FULL.
  - ONE, output transfer only: clear main control, go to EMPTY.
  - FULL, output transfer: move skid to main, go to ONE. `ready_o` = 0 in FULL, so there is no input transfer.
- Order is strictly FIFO; no entry is dropped or duplicated except by flush.
- Flush has the highest priority:
  - Next state is EMPTY, `valid_o` = 0, `ctrl_o` = 0, skid entry discarded.
  - An input transfer in the flush cycle is discarded.
  - `data_o` is unchanged.
- `stall_cnt_o` increments on every cycle with `valid_o & !ready_i & !flush_i`.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.

## Timing
- Reset values:
  - `valid_o` = 0, `ctrl_o` = 0, `data_o` = 0, `stall_cnt_o` = 0.
  - `ready_o` = 1 in both modes.
  - State = EMPTY.
- Latency: an entry accepted at edge N appears on `valid_o`/`ctrl_o`/`data_o` after edge N.
- Throughput: one entry per cycle in both modes with `ready_i` held at 1.
- Skid mode: `ready_o` is registered, with no combinational path from `ready_i`. It drops the cycle after the skid fills and rises the cycle after the skid drains.
- Flush asserted in the same cycle as a ready_i drop: flush wins, and the stall counter does not increment.
- Asynchronous reset mid-transfer: outputs clear immediately; the entry is lost.

## Configuration
- `PIPE_STAGE_SKID_EN`
  - Defined: skid mode, two-entry buffer with registered `ready_o`.
  - Undefined: base mode, one entry with combinational `ready_o`.
- Ports and parameters are identical in both modes.

## Test plan
- Reset check: assert `rst_i`=0 mid-run with `valid_o`=1 and `ctrl_i`=8'hA5 loaded → `valid_o`/`ctrl_o`/`data_o`/`stall_cnt_o` read 0 before the next edge, and `ready_o`=1.
- Streaming: `ready_i`=1, 10 back-to-back entries with `data_i`=0..9 → `data_o`=0..9 on consecutive cycles, one cycle after each input, and `stall_cnt_o` stays 0.
- Back-pressure:
  - Stimulus: `ready_i`=0 for 3 cycles while streaming 0,1,2,...
  - Skid mode: `ready_o` falls one cycle after 1 enters the skid.
  - Both modes: `data_o` holds 0 for 3 cycles, then outputs 1,2,... in order, and `stall_cnt_o`=3.
- Flush:
  - Stimulus: FULL state holding entries 5 and 6, with `flush_i`=1 and `valid_i`=1 carrying 7.
  - Next cycle: `valid_o`=0, `ctrl_o`=0, state EMPTY.
  - Entries 5, 6 and 7 never appear at the output.
- Bubble: a single entry with `ctrl_i`=8'hFF, then `valid_i`=0 with `ready_i`=1 → `ctrl_o` returns to 0 one cycle after the output transfer.
- Saturation: `CNT_W`=4, `ready_i`=0 for 20 cycles with `valid_o`=1 → `stall_cnt_o` stops at 15.
